// File: rtl/button_event_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : button_event_encoder_if
// Purpose  : Raw button inputs and encoded event outputs of the button
//            event encoder, grouped for the controller connection.
// Revision : 1.0 - initial release
// ============================================================================
interface button_event_encoder_if;
  logic       enter0;
  logic       enter1;
  logic       confirm;
  logic       clear;
  logic       algorithm_select_mode;
  logic       events_en;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_collision;
  logic       busy;

  modport master (
    output enter0, enter1, confirm, clear, algorithm_select_mode, events_en,
    input  evt_valid, evt_code, evt_collision, busy
  );

  modport slave (
    input  enter0, enter1, confirm, clear, algorithm_select_mode, events_en,
    output evt_valid, evt_code, evt_collision, busy
  );
endinterface
`default_nettype wire

// File: rtl/button_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : button_event_encoder
// Purpose  : Synchronise, debounce and edge-detect five push buttons and emit
//            one encoded single-cycle event per clean press.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_encoder #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  button_event_encoder_if.slave  bus
);

  localparam int                 c_NUM_BTN  = 5;
  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [c_NUM_BTN-1:0] w_raw;
  logic [c_NUM_BTN-1:0] w_deb;
  logic [c_NUM_BTN-1:0] w_deb_next;
  logic [c_NUM_BTN-1:0] w_rise;
  logic                 w_single;
  logic                 w_clean;
  logic                 w_accept;
  logic                 w_reject;
  logic [2:0]           w_code;

  logic                 r_pend_valid;
  logic [2:0]           r_pend_code;
  logic                 r_pend_coll;
  logic                 r_evt_valid;
  logic [2:0]           r_evt_code;
  logic                 r_evt_coll;
  logic                 r_busy;

  // Bit index + 1 is the event code.
  assign w_raw = {bus.algorithm_select_mode, bus.clear, bus.confirm,
                  bus.enter1, bus.enter0};

  generate
    for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
      logic               r_s1;
      logic               r_s2;
      logic               r_deb;
      logic [c_CNT_W-1:0] r_cnt;
      logic               w_mismatch;
      logic               w_flip;

      assign w_mismatch = r_s2 ^ r_deb;
      assign w_flip     = w_mismatch && (r_cnt == c_CNT_LAST);

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_s1  <= 1'b0;
          r_s2  <= 1'b0;
          r_deb <= 1'b0;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
          if (!w_mismatch || w_flip) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
          if (w_flip) begin
            r_deb <= ~r_deb;
          end
        end
      end

      assign w_deb[gi]      = r_deb;
      assign w_deb_next[gi] = r_deb ^ w_flip;
    end
  endgenerate

  // A press is clean only when it is the sole rise and nothing else was held.
  assign w_rise   = w_deb_next & ~w_deb;
  assign w_single = (w_rise != '0) && ((w_rise & (w_rise - 5'd1)) == '0);
  assign w_clean  = w_single && (w_deb == '0);
  assign w_accept = w_clean && bus.events_en;
  assign w_reject = (w_rise != '0) && !w_clean;

  always_comb begin
    w_code = 3'd0;
    for (int i = 0; i < c_NUM_BTN; i++) begin
      if (w_rise[i]) begin
        w_code = 3'(i + 1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_code  <= 3'd0;
      r_pend_coll  <= 1'b0;
      r_evt_valid  <= 1'b0;
      r_evt_code   <= 3'd0;
      r_evt_coll   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_pend_valid <= w_accept;
      r_pend_code  <= w_accept ? w_code : 3'd0;
      r_pend_coll  <= w_reject;
      r_evt_valid  <= r_pend_valid;
      r_evt_code   <= r_pend_code;
      r_evt_coll   <= r_pend_coll;
      r_busy       <= |w_deb;
    end
  end

  assign bus.evt_valid     = r_evt_valid;
  assign bus.evt_code      = r_evt_code;
  assign bus.evt_collision = r_evt_coll;
  assign bus.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_button_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_encoder
// Purpose  : Self-checking bench for button_event_encoder (DEBOUNCE_CYCLES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_encoder;

  localparam int D = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  button_event_encoder_if bus ();

  button_event_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] mask;
    bit         en;
    int         hi;
    int         exp_ev;
    int         exp_code;
    int         exp_coll;
    int         exp_lat;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state: raw sample history and debounced levels.
  bit       hist [5][$];
  bit       m_deb [5];
  bit       m_pend_valid, m_pend_coll, m_valid, m_coll, m_busy;
  bit [2:0] m_pend_code, m_code;

  logic [2:0] ev_code_q [$];
  int         ev_cyc_q [$];
  int         coll_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pend_valid = 0; m_pend_code = 0; m_pend_coll = 0;
    m_valid = 0; m_code = 0; m_coll = 0; m_busy = 0;
    for (int b = 0; b < 5; b++) begin
      m_deb[b] = 0;
      hist[b].delete();
    end
  endtask

  // A level flips once the D most recent synchronised samples all disagree.
  task automatic model_step();
    bit raw [5];
    bit nd [5];
    bit anyold, flip, s;
    int nrise, idx;
    raw[0] = bus.enter0; raw[1] = bus.enter1; raw[2] = bus.confirm;
    raw[3] = bus.clear;  raw[4] = bus.algorithm_select_mode;
    m_valid = m_pend_valid; m_code = m_pend_code; m_coll = m_pend_coll;
    anyold = 0;
    for (int b = 0; b < 5; b++) if (m_deb[b]) anyold = 1;
    m_busy = anyold;
    nrise = 0; idx = 0;
    for (int b = 0; b < 5; b++) begin
      flip = 1;
      for (int j = 1; j <= D; j++) begin
        s = (hist[b].size() > j) ? hist[b][j] : 1'b0;
        if (s == m_deb[b]) flip = 0;
      end
      nd[b] = m_deb[b] ^ flip;
      if (nd[b] && !m_deb[b]) begin nrise++; idx = b; end
    end
    m_pend_valid = (nrise == 1) && !anyold && bus.events_en;
    m_pend_code  = m_pend_valid ? 3'(idx + 1) : 3'd0;
    m_pend_coll  = (nrise > 0) && !((nrise == 1) && !anyold);
    for (int b = 0; b < 5; b++) begin
      m_deb[b] = nd[b];
      hist[b].push_front(raw[b]);
      if (hist[b].size() > D + 2) void'(hist[b].pop_back());
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_reset(); else model_step();
    @(negedge clock);
    cyc++;
    check("evt_valid", bus.evt_valid, m_valid);
    check("evt_code", bus.evt_code, m_code);
    check("evt_collision", bus.evt_collision, m_coll);
    check("busy", bus.busy, m_busy);
    if (bus.evt_valid === 1'b1) begin
      ev_code_q.push_back(bus.evt_code);
      ev_cyc_q.push_back(cyc);
    end
    if (bus.evt_collision === 1'b1) coll_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input logic [4:0] m);
    bus.enter0 = m[0]; bus.enter1 = m[1]; bus.confirm = m[2];
    bus.clear = m[3]; bus.algorithm_select_mode = m[4];
  endtask

  task automatic clear_log();
    ev_code_q.delete();
    ev_cyc_q.delete();
    coll_cnt = 0;
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("rst_evt_valid", bus.evt_valid, 0);
    check("rst_evt_code", bus.evt_code, 0);
    check("rst_evt_collision", bus.evt_collision, 0);
    check("rst_busy", bus.busy, 0);
    ticks(2);
  endtask

  vec_t vecs [8];
  int   start;
  int   seq_codes [7] = '{2, 1, 2, 2, 1, 2, 3};

  initial begin
    vecs[0] = '{5'b00010, 1'b1, 3, 1, 2, 0, 4};
    vecs[1] = '{5'b01000, 1'b1, 1, 0, 0, 0, -1};
    vecs[2] = '{5'b00011, 1'b1, 3, 0, 0, 1, -1};
    vecs[3] = '{5'b10000, 1'b0, 3, 0, 0, 0, -1};
    vecs[4] = '{5'b00100, 1'b1, 3, 1, 3, 0, 4};
    vecs[5] = '{5'b10000, 1'b1, 3, 1, 5, 0, 4};
    vecs[6] = '{5'b00001, 1'b1, 2, 1, 1, 0, 4};
    vecs[7] = '{5'b10101, 1'b1, 4, 0, 0, 1, -1};

    set_btn(5'b0);
    bus.events_en = 1'b1;
    model_reset();
    clear_log();
    @(negedge clock);
    @(negedge clock);
    check("reset_evt_valid", bus.evt_valid, 0);
    check("reset_evt_code", bus.evt_code, 0);
    check("reset_evt_collision", bus.evt_collision, 0);
    check("reset_busy", bus.busy, 0);
    reset = 1'b0;
    ticks(3);

    // Table-driven single presses.
    foreach (vecs[v]) begin
      clear_log();
      bus.events_en = vecs[v].en;
      start = cyc;
      set_btn(vecs[v].mask);
      ticks(vecs[v].hi);
      set_btn(5'b0);
      ticks(12);
      bus.events_en = 1'b1;
      check($sformatf("vec%0d_events", v), ev_code_q.size(), vecs[v].exp_ev);
      check($sformatf("vec%0d_collisions", v), coll_cnt, vecs[v].exp_coll);
      if (vecs[v].exp_ev > 0 && ev_code_q.size() > 0) begin
        check($sformatf("vec%0d_code", v), ev_code_q[0], vecs[v].exp_code);
        check($sformatf("vec%0d_latency", v), ev_cyc_q[0] - start - 1, vecs[v].exp_lat);
      end
    end

    // Full password sequence.
    clear_log();
    foreach (seq_codes[i]) begin
      set_btn(5'(1 << (seq_codes[i] - 1)));
      ticks(3);
      set_btn(5'b0);
      ticks(3);
    end
    ticks(10);
    check("seq_events", ev_code_q.size(), 7);
    check("seq_collisions", coll_cnt, 0);
    check("seq_busy_end", bus.busy, 0);
    if (ev_code_q.size() == 7) begin
      foreach (seq_codes[i]) begin
        check($sformatf("seq_code%0d", i), ev_code_q[i], seq_codes[i]);
        if (i > 0) check($sformatf("seq_gap%0d", i), ev_cyc_q[i] - ev_cyc_q[i-1], 6);
      end
    end

    // Single-cycle dropout mid-press.
    clear_log();
    set_btn(5'b00100); ticks(3);
    set_btn(5'b00000); ticks(1);
    set_btn(5'b00100); ticks(3);
    set_btn(5'b00000); ticks(12);
    check("glitch_events", ev_code_q.size(), 1);
    check("glitch_collisions", coll_cnt, 0);
    if (ev_code_q.size() > 0) check("glitch_code", ev_code_q[0], 3);

    // Chord: enter0 held, confirm pressed on top.
    clear_log();
    set_btn(5'b00001); ticks(6);
    set_btn(5'b00101); ticks(3);
    set_btn(5'b00001); ticks(3);
    set_btn(5'b00000); ticks(12);
    check("chord_events", ev_code_q.size(), 1);
    check("chord_collisions", coll_cnt, 1);
    if (ev_code_q.size() > 0) check("chord_code", ev_code_q[0], 1);

    // Enable raised while the press is still held.
    clear_log();
    bus.events_en = 1'b0;
    set_btn(5'b10000); ticks(8);
    bus.events_en = 1'b1; ticks(6);
    set_btn(5'b00000); ticks(12);
    check("late_en_events", ev_code_q.size(), 0);
    check("late_en_collisions", coll_cnt, 0);
    clear_log();
    set_btn(5'b10000); ticks(3);
    set_btn(5'b00000); ticks(12);
    check("after_en_events", ev_code_q.size(), 1);
    if (ev_code_q.size() > 0) check("after_en_code", ev_code_q[0], 5);

    // Reset while an event is pending.
    clear_log();
    set_btn(5'b00010); ticks(4);
    async_reset_pulse();
    set_btn(5'b00000);
    reset = 1'b0;
    ticks(10);
    check("rst_pending_events", ev_code_q.size(), 0);

    // Button held through reset release is a fresh press.
    set_btn(5'b00010); ticks(8);
    check("held_busy", bus.busy, 1);
    async_reset_pulse();
    clear_log();
    reset = 1'b0;
    start = cyc;
    ticks(8);
    set_btn(5'b00000); ticks(10);
    check("held_rst_events", ev_code_q.size(), 1);
    if (ev_code_q.size() > 0) begin
      check("held_rst_code", ev_code_q[0], 2);
      check("held_rst_latency", ev_cyc_q[0] - start - 1, 4);
    end

    // Random button activity against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 7) == 0) begin
          case (b)
            0: bus.enter0 = ~bus.enter0;
            1: bus.enter1 = ~bus.enter1;
            2: bus.confirm = ~bus.confirm;
            3: bus.clear = ~bus.clear;
            default: bus.algorithm_select_mode = ~bus.algorithm_select_mode;
          endcase
        end
      end
      if ($urandom_range(0, 31) == 0) bus.events_en = ~bus.events_en;
      tick();
    end
    set_btn(5'b00000);
    bus.events_en = 1'b1;
    ticks(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
